// File: rtl/key_vault_pkg.sv
// ---------------------------------------------------------------------------
// key_vault_pkg
// Shared types and constants for the key vault register file:
//   - state_e     : controller state (INIT walk / RUN service)
//   - rsp_err_e   : response error codes returned on rsp_err
//   - VIOL_W      : width of the saturating violation counter
//   - classify_err: folds the individual check results into one error code
// ---------------------------------------------------------------------------
package key_vault_pkg;

   typedef enum logic {
      INIT = 1'b0,
      RUN  = 1'b1
   } state_e;

   typedef enum logic [1:0] {
      ERR_OK    = 2'd0,
      ERR_PROT  = 2'd1,
      ERR_RANGE = 2'd2,
      ERR_ALIGN = 2'd3
   } rsp_err_e;

   localparam int VIOL_W = 8;

   // Alignment is reported first, then range, then protection, so that a
   // malformed address never gets attributed to the lock.
   function automatic rsp_err_e classify_err(input logic align_bad,
                                             input logic range_bad,
                                             input logic prot_bad);
      if (align_bad)      return ERR_ALIGN;
      else if (range_bad) return ERR_RANGE;
      else if (prot_bad)  return ERR_PROT;
      else                return ERR_OK;
   endfunction

endpackage

// File: rtl/key_vault_sat_counter.sv
// ---------------------------------------------------------------------------
// sat_counter
// Up-counter that sticks at its all-ones value.
// Ports:
//   clk     : clock
//   clr_i   : synchronous clear (takes priority over inc_i)
//   inc_i   : add one this cycle unless already saturated
//   count_o : current count
// ---------------------------------------------------------------------------
module sat_counter #(
   parameter int W = 8
) (
   input  logic         clk,
   input  logic         clr_i,
   input  logic         inc_i,
   output logic [W-1:0] count_o
);

   logic [W-1:0] count_q;

   // NOTE: state registers are only ever assigned with non-blocking (<=)
   // inside always_ff, so every flop samples the pre-edge value of its peers.
   always_ff @(posedge clk) begin
      if (clr_i) begin
         count_q <= '0;
      end else if (inc_i && (count_q != '1)) begin
         count_q <= count_q + 1'b1;
      end
   end

   assign count_o = count_q;

endmodule

// File: rtl/key_vault_regfile.sv
// ---------------------------------------------------------------------------
// key_vault_regfile
// Word-addressed register file whose low PROT_N entries hold key material.
// After reset an init walk loads every entry (protected entries get
// KEY_VAL ^ index, the rest zero). Protected entries stay writable until the
// sticky lock is set; afterwards writes to them are rejected. Every rejected
// request (misaligned, out of range, or locked-protected write) returns an
// error code, leaves the array untouched and bumps a saturating counter.
// Ports:
//   clk, reset     : clock, synchronous active-high reset
//   req_valid/ready: request handshake, ready only once the walk is done
//   req_we         : 1 = write, 0 = read
//   req_addr       : byte address (word index in bits [2 +: IDX_W])
//   req_wdata      : write data
//   lock_set       : pulse, sets the sticky lock
//   locked         : current lock state
//   busy           : init walk in progress
//   rsp_valid      : one-cycle response pulse, one cycle after acceptance
//   rsp_rdata      : read data, echoed write data, or 0 on error
//   rsp_err        : rsp_err_e code
//   viol_count     : saturating count of rejected requests
// ---------------------------------------------------------------------------
module key_vault_regfile
   import key_vault_pkg::*;
#(
   parameter int          DATA_W  = 32,
   parameter int          DEPTH   = 32,
   parameter int          PROT_N  = 4,
   parameter logic [31:0] KEY_VAL = 32'h1035_9987
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              req_valid,
   output logic              req_ready,
   input  logic              req_we,
   input  logic [31:0]       req_addr,
   input  logic [DATA_W-1:0] req_wdata,
   input  logic              lock_set,
   output logic              locked,
   output logic              busy,
   output logic              rsp_valid,
   output logic [DATA_W-1:0] rsp_rdata,
   output logic [1:0]        rsp_err,
   output logic [VIOL_W-1:0] viol_count
);

   localparam int IDX_W = $clog2(DEPTH);

   // ---------------- registers ----------------
   state_e             state_q;
   logic [IDX_W-1:0]   walk_idx_q;
   logic               locked_q;
   logic               rsp_valid_q;
   logic [DATA_W-1:0]  rsp_rdata_q;
   rsp_err_e           rsp_err_q;
   logic [DATA_W-1:0]  mem_q [DEPTH];

   // ---------------- request decode ----------------
   logic               accept;
   logic [IDX_W-1:0]   req_idx;
   logic               align_bad;
   logic               range_bad;
   logic               prot_bad;
   rsp_err_e           err_d;
   logic [DATA_W-1:0]  rsp_rdata_d;

   assign accept    = req_valid && (state_q == RUN);
   assign req_idx   = req_addr[2 +: IDX_W];
   assign align_bad = |req_addr[1:0];
   assign range_bad = (req_addr >> (2 + IDX_W)) != '0;
   // The lock is checked against its registered value, so a lock_set pulse
   // arriving with a protected write lets that write through.
   assign prot_bad  = req_we && locked_q && (int'(req_idx) < PROT_N);
   assign err_d     = classify_err(align_bad, range_bad, prot_bad);

   always_comb begin
      // NOTE: every always_comb output is given a default before any branch,
      // so no path leaves it unassigned and no latch is inferred.
      rsp_rdata_d = '0;
      if (err_d == ERR_OK) begin
         rsp_rdata_d = req_we ? req_wdata : mem_q[req_idx];
      end
   end

   // ---------------- single array write port ----------------
   // The walk owns the port in INIT, requests own it in RUN.
   logic               mem_we;
   logic [IDX_W-1:0]   mem_widx;
   logic [DATA_W-1:0]  mem_wdata;
   logic [DATA_W-1:0]  init_val;

   assign init_val = (int'(walk_idx_q) < PROT_N)
                   ? (DATA_W'(KEY_VAL) ^ DATA_W'(walk_idx_q))
                   : '0;

   always_comb begin
      mem_we    = 1'b0;
      mem_widx  = walk_idx_q;
      mem_wdata = init_val;
      if (state_q == INIT) begin
         mem_we = 1'b1;
      end else if (accept && req_we && (err_d == ERR_OK)) begin
         mem_we    = 1'b1;
         mem_widx  = req_idx;
         mem_wdata = req_wdata;
      end
   end

   // NOTE: the array has no reset branch; the init walk overwrites every
   // entry before the first request can be accepted, so resetting it would
   // only add a mux per bit.
   always_ff @(posedge clk) begin
      if (mem_we) begin
         mem_q[mem_widx] <= mem_wdata;
      end
   end

   // ---------------- controller FSM with registered outputs ----------------
   always_ff @(posedge clk) begin
      if (reset) begin
         state_q     <= INIT;
         walk_idx_q  <= '0;
         locked_q    <= 1'b0;
         rsp_valid_q <= 1'b0;
         rsp_rdata_q <= '0;
         rsp_err_q   <= ERR_OK;
      end else begin
         locked_q    <= locked_q | lock_set;
         rsp_valid_q <= accept;
         if (accept) begin
            rsp_rdata_q <= rsp_rdata_d;
            rsp_err_q   <= err_d;
         end
         unique case (state_q)
            INIT: begin
               walk_idx_q <= walk_idx_q + 1'b1;
               if (walk_idx_q == IDX_W'(DEPTH - 1)) begin
                  state_q <= RUN;
               end
            end
            RUN: begin
               state_q <= RUN;
            end
         endcase
      end
   end

   // ---------------- violation counter ----------------
   sat_counter #(
      .W(VIOL_W)
   ) u_viol_cnt (
      .clk     (clk),
      .clr_i   (reset),
      .inc_i   (accept && (err_d != ERR_OK)),
      .count_o (viol_count)
   );

   // ---------------- outputs ----------------
   assign req_ready = (state_q == RUN);
   assign busy      = (state_q == INIT);
   assign locked    = locked_q;
   assign rsp_valid = rsp_valid_q;
   assign rsp_rdata = rsp_rdata_q;
   assign rsp_err   = rsp_err_q;

endmodule
